// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Mealy hold/flush controls for load-use, jump, divider waits and memory wait-states.
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_reg1_raddr_i,
  input  logic [4:0]       id_reg2_raddr_i,
  input  logic             id_reg1_RE_i,
  input  logic             id_reg2_RE_i,
  input  logic [4:0]       id_ex_reg_reg_waddr_i,
  input  logic             id_ex_reg_mem_re_i,
  input  logic             ex_jump_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             ex_div_start_i,
  input  logic             div_ready_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_hold_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic             pc_jump_o,
  output logic [31:0]      pc_jump_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             div_timeout_o,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {RUN = 2'd0, DIV_WAIT = 2'd1, MEM_WAIT = 2'd2} state_t;
  state_t           r_state, w_next;
  logic [31:0]      r_div_cnt, w_div_cnt;
  logic             r_to, w_to;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_pc_hold, w_if_id_hold, w_if_id_flush, w_id_ex_hold, w_id_ex_flush;
  logic             w_ex_mem_hold, w_ex_mem_flush, w_mem_wb_flush, w_jump;
  logic             w_load_use, w_mem_stall;
  assign w_mem_stall = mem_req_i & ~mem_ack_i;
  assign w_load_use  = id_ex_reg_mem_re_i & (id_ex_reg_reg_waddr_i != 5'd0) &
                       ((id_reg1_RE_i & (id_reg1_raddr_i == id_ex_reg_reg_waddr_i)) |
                        (id_reg2_RE_i & (id_reg2_raddr_i == id_ex_reg_reg_waddr_i)));
  always_comb begin
    w_pc_hold      = 1'b0;
    w_if_id_hold   = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_hold   = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_hold  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mem_wb_flush = 1'b0;
    w_jump         = 1'b0;
    w_next         = r_state;
    w_div_cnt      = r_div_cnt;
    w_to           = r_to;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          {w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_hold, w_mem_wb_flush} = '1;
          w_next = MEM_WAIT;
        end else if (ex_div_start_i) begin
          {w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_flush} = '1;
          w_next    = DIV_WAIT;
          w_div_cnt = 32'd1;
        end else if (ex_jump_i) begin
          {w_jump, w_if_id_flush, w_id_ex_flush} = '1;
        end else if (w_load_use) begin
          {w_pc_hold, w_if_id_hold, w_id_ex_flush} = '1;
        end
      end
      DIV_WAIT: begin
        if (div_ready_i) begin
          w_next    = RUN;
          w_div_cnt = 32'd0;
        end else if (r_div_cnt >= 32'(DIV_TIMEOUT)) begin
          w_next    = RUN;
          w_div_cnt = 32'd0;
          w_to      = 1'b1;
        end else begin
          {w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_flush} = '1;
          w_div_cnt = r_div_cnt + 32'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) w_next = RUN;
        else {w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_hold, w_mem_wb_flush} = '1;
      end
      default: w_next = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_div_cnt   <= 32'd0;
      r_to        <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_div_cnt <= w_div_cnt;
      r_to      <= w_to;
      if (w_pc_hold && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  // Controls are gated so they read 0 for the whole time reset is held.
  assign pc_hold_o      = rst_n & w_pc_hold;
  assign if_id_hold_o   = rst_n & w_if_id_hold;
  assign if_id_flush_o  = rst_n & w_if_id_flush;
  assign id_ex_hold_o   = rst_n & w_id_ex_hold;
  assign id_ex_flush_o  = rst_n & w_id_ex_flush;
  assign ex_mem_hold_o  = rst_n & w_ex_mem_hold;
  assign ex_mem_flush_o = rst_n & w_ex_mem_flush;
  assign mem_wb_flush_o = rst_n & w_mem_wb_flush;
  assign pc_jump_o      = rst_n & w_jump;
  assign pc_jump_addr_o = (rst_n & w_jump) ? ex_jump_addr_i : 32'd0;
  assign stall_cnt_o    = r_stall_cnt;
  assign div_timeout_o  = r_to;
  assign state_o        = r_state;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plan steps plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  localparam int TO    = 8;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [8:0] FREEZE = 9'b110101010;
  localparam logic [8:0] DIVH   = 9'b110100100;
  localparam logic [8:0] JMP    = 9'b001010001;
  localparam logic [8:0] LU     = 9'b110010000;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] r1, r2, waddr;
  logic re1, re2, mem_re, jump, start, ready, req, ack;
  logic [31:0] jaddr;
  logic pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic ex_mem_hold, ex_mem_flush, mem_wb_flush, pc_jump;
  logic [31:0] pc_jump_addr;
  logic [CW-1:0] stall_cnt;
  logic div_to;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;
  logic m_mem;
  int m_div;
  logic m_to;
  int m_cnt;
  logic [8:0] e_ctl;
  logic [31:0] e_addr;
  pipe_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg1_raddr_i(r1), .id_reg2_raddr_i(r2),
    .id_reg1_RE_i(re1), .id_reg2_RE_i(re2),
    .id_ex_reg_reg_waddr_i(waddr), .id_ex_reg_mem_re_i(mem_re),
    .ex_jump_i(jump), .ex_jump_addr_i(jaddr),
    .ex_div_start_i(start), .div_ready_i(ready),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold), .if_id_flush_o(if_id_flush),
    .id_ex_hold_o(id_ex_hold), .id_ex_flush_o(id_ex_flush),
    .ex_mem_hold_o(ex_mem_hold), .ex_mem_flush_o(ex_mem_flush),
    .mem_wb_flush_o(mem_wb_flush), .pc_jump_o(pc_jump), .pc_jump_addr_o(pc_jump_addr),
    .stall_cnt_o(stall_cnt), .div_timeout_o(div_to), .state_o(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {r1, r2, waddr} = '0;
    {re1, re2, mem_re, jump, start, ready, req, ack} = '0;
    jaddr = 32'd0;
  endtask
  task automatic model_clear();
    m_mem = 1'b0; m_div = 0; m_to = 1'b0; m_cnt = 0;
  endtask
  task automatic predict();
    logic lu;
    lu = mem_re && waddr != 0 && ((re1 && r1 == waddr) || (re2 && r2 == waddr));
    if (!rst_n) e_ctl = '0;
    else if (m_mem) e_ctl = ack ? 9'd0 : FREEZE;
    else if (m_div > 0) e_ctl = (ready || m_div >= TO) ? 9'd0 : DIVH;
    else if (req && !ack) e_ctl = FREEZE;
    else if (start) e_ctl = DIVH;
    else if (jump) e_ctl = JMP;
    else if (lu) e_ctl = LU;
    else e_ctl = '0;
    e_addr = e_ctl[0] ? jaddr : 32'd0;
  endtask
  task automatic advance();
    if (m_mem) m_mem = !ack;
    else if (m_div > 0) begin
      if (ready) m_div = 0;
      else if (m_div >= TO) begin m_div = 0; m_to = 1'b1; end
      else m_div++;
    end
    else if (req && !ack) m_mem = 1'b1;
    else if (start) m_div = 1;
    if (e_ctl[8] && m_cnt < CMAX) m_cnt++;
  endtask
  task automatic cycle();
    @(negedge clk);
    predict();
    chk("ctl", 64'({pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                    ex_mem_hold, ex_mem_flush, mem_wb_flush, pc_jump}), 64'(e_ctl));
    chk("jump_addr", 64'(pc_jump_addr), 64'(e_addr));
    chk("hold_flush_excl", 64'((if_id_hold & if_id_flush) | (id_ex_hold & id_ex_flush) |
                               (ex_mem_hold & ex_mem_flush)), 64'd0);
    @(posedge clk);
    #1;
    advance();
    chk("state", 64'(state), 64'(m_div > 0 ? 1 : (m_mem ? 2 : 0)));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("div_timeout", 64'(div_to), 64'(m_to));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", 64'({pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                        ex_mem_hold, ex_mem_flush, mem_wb_flush, pc_jump}), 64'd0);
    chk("rst_addr", 64'(pc_jump_addr), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_to", 64'(div_to), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    idle();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_reset();
    // load-use on rs2, then clear
    mem_re = 1'b1; waddr = 5'd5; r2 = 5'd5; re2 = 1'b1; r1 = 5'd7; re1 = 1'b1;
    cycle();
    idle();
    cycle();
    chk("lu_cnt", 64'(stall_cnt), 64'd1);
    mem_re = 1'b1; waddr = 5'd0; r2 = 5'd0; re2 = 1'b1;
    cycle();
    chk("lu_x0_cnt", 64'(stall_cnt), 64'd1);
    // jump together with a load-use hit
    idle();
    mem_re = 1'b1; waddr = 5'd9; r1 = 5'd9; re1 = 1'b1; jump = 1'b1; jaddr = 32'h0000_0100;
    cycle();
    chk("jlu_addr", 64'(pc_jump_addr), 64'h100);
    chk("jlu_pc_hold", 64'(pc_hold), 64'd0);
    // memory wait, three cycles of no ack
    idle();
    do_reset();
    req = 1'b1;
    repeat (3) cycle();
    chk("mw_state", 64'(state), 64'd2);
    ack = 1'b1;
    cycle();
    chk("mw_cnt", 64'(stall_cnt), 64'd3);
    chk("mw_state_done", 64'(state), 64'd0);
    // divide completing after five wait cycles
    idle();
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    ready = 1'b1;
    cycle();
    chk("div_cnt", 64'(stall_cnt), 64'd6);
    chk("div_state", 64'(state), 64'd0);
    chk("div_to", 64'(div_to), 64'd0);
    // divider timeout
    idle();
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (7) cycle();
    chk("to_pending", 64'(div_to), 64'd0);
    cycle();
    chk("to_set", 64'(div_to), 64'd1);
    chk("to_state", 64'(state), 64'd0);
    chk("to_cnt", 64'(stall_cnt), 64'd8);
    repeat (2) cycle();
    chk("to_sticky", 64'(div_to), 64'd1);
    // async reset while in MEM_WAIT
    idle();
    req = 1'b1;
    repeat (2) cycle();
    chk("pre_rst_state", 64'(state), 64'd2);
    do_reset();
    // randomized traffic
    idle();
    for (int i = 0; i < 3000; i++) begin
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      waddr = 5'($urandom_range(0, 3));
      re1 = 1'($urandom_range(0, 1));
      re2 = 1'($urandom_range(0, 1));
      mem_re = ($urandom_range(0, 2) == 0);
      jump = ($urandom_range(0, 4) == 0);
      jaddr = $urandom;
      start = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 6) == 0);
      req = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage rv32core pipeline (IF, ID, EX, MEM, WB).
- Generates per-stage hold (freeze) and flush (bubble) controls for the pc and the four stage registers.
- Handles load-use stalls, EX-stage jump redirect, multi-cycle divider waits and MEM-stage memory wait-states.
- Keeps a saturating stall-cycle counter and a sticky divider-timeout flag.

Parameters:
- DIV_TIMEOUT, 64: maximum DIV_WAIT cycles before the wait is abandoned.
- CNT_W, 32: width of stall_cnt_o.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_reg1_raddr_i  in  5  ID source register 1 address
- id_reg2_raddr_i  in  5  ID source register 2 address
- id_reg1_RE_i  in  1  ID reads rs1
- id_reg2_RE_i  in  1  ID reads rs2
- id_ex_reg_reg_waddr_i  in  5  destination register of the instruction in EX
- id_ex_reg_mem_re_i  in  1  instruction in EX is a load
- ex_jump_i  in  1  EX resolves a taken branch or jump
- ex_jump_addr_i  in  32  redirect target
- ex_div_start_i  in  1  EX issues a multi-cycle divide
- div_ready_i  in  1  divider result valid
- mem_req_i  in  1  MEM stage issues a data-memory access
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_hold_o  out  1  freeze pc
- if_id_hold_o  out  1  freeze IF/ID register
- if_id_flush_o  out  1  load a bubble into IF/ID
- id_ex_hold_o  out  1  freeze ID/EX register
- id_ex_flush_o  out  1  load a bubble into ID/EX
- ex_mem_hold_o  out  1  freeze EX/MEM register
- ex_mem_flush_o  out  1  load a bubble into EX/MEM
- mem_wb_flush_o  out  1  load a bubble into MEM/WB
- pc_jump_o  out  1  pc takes pc_jump_addr_o next edge
- pc_jump_addr_o  out  32  redirect target
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_hold_o=1
- div_timeout_o  out  1  sticky divider-timeout error
- state_o  out  2  FSM state: 0 RUN, 1 DIV_WAIT, 2 MEM_WAIT

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, stall_cnt_o=0, div_timeout_o=0, internal div counter=0.
  - All control outputs and pc_jump_addr_o forced to 0 while rst_n=0.
- All control outputs are combinational (Mealy) from state and inputs; they take effect at the next clk edge. Zero added pipeline latency.
- Per stage register, hold and flush are never asserted together.
- Priority, highest first: MEM freeze > DIV wait > jump > load-use.
- RUN, memory freeze (mem_req_i=1, mem_ack_i=0):
  - pc/if_id/id_ex/ex_mem holds=1, mem_wb_flush_o=1, all other outputs 0.
  - Next state MEM_WAIT.
  - mem_req_i=1 with mem_ack_i=1 in the same cycle causes no stall.
- RUN, divider start (ex_div_start_i=1):
  - pc/if_id/id_ex holds=1, ex_mem_flush_o=1.
  - Next state DIV_WAIT; div counter=1.
- RUN, jump (ex_jump_i=1):
  - pc_jump_o=1, pc_jump_addr_o=ex_jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1.
  - Any simultaneous load-use condition is ignored, because the ID instruction is flushed.
- RUN, load-use:
  - Condition: id_ex_reg_mem_re_i=1, id_ex_reg_reg_waddr_i!=0, and (id_reg1_RE_i and raddr1==waddr) or (id_reg2_RE_i and raddr2==waddr).
  - Response: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 for exactly that cycle, giving one bubble.
  - The condition clears on the next cycle because the load has moved to MEM.
- MEM_WAIT:
  - Outputs as in the RUN memory-freeze case while mem_ack_i=0.
  - On mem_ack_i=1, all outputs are 0 that cycle and next state is RUN.
  - A jump or load-use pending in EX/ID is re-evaluated in RUN on the following cycle.
- DIV_WAIT:
  - pc/if_id/id_ex holds=1 and ex_mem_flush_o=1 each cycle; div counter increments.
  - div_ready_i=1: all outputs 0 that cycle, so the result advances; next state RUN.
  - If div counter reaches DIV_TIMEOUT with div_ready_i=0: div_timeout_o is set to 1 (sticky until reset), outputs are 0 that cycle, next state RUN.
  - mem_req_i is ignored in DIV_WAIT because MEM holds a bubble.
- stall_cnt_o: +1 on every clk edge where pc_hold_o=1; saturates at all-ones.
- Reset mid-operation (any state): immediate return to RUN; counters and flags cleared.

Test Plan:
- Load-use: EX holds a load to x5; ID reads rs2=x5 with RE2=1 -> one cycle of pc_hold_o=if_id_hold_o=id_ex_flush_o=1, then all 0; stall_cnt_o=1. Repeat with waddr=0 -> no stall.
- Jump plus load-use together: ex_jump_i=1, addr 0x0000_0100, with a load-use hit -> pc_jump_o=1, pc_jump_addr_o=0x100, if_id_flush_o=id_ex_flush_o=1, pc_hold_o=0.
- Memory wait: mem_req_i=1 with mem_ack_i low for 3 cycles, then high -> state_o=2 for 3 cycles, holds high and mem_wb_flush_o=1 for 3 cycles, released on the ack cycle; stall_cnt_o=3.
- Divide: ex_div_start_i pulse, then div_ready_i after 5 cycles -> holds high 5 cycles plus the start cycle, ex_mem_flush_o high, state returns to 0, div_timeout_o=0.
- Timeout: DIV_TIMEOUT=8, div_ready_i never asserted -> state_o=1 until the count reaches 8, then div_timeout_o=1 (sticky) and state_o=0.
- Reset asserted asynchronously during MEM_WAIT -> all outputs immediately 0, state_o=0, stall_cnt_o=0.
